// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and widths for the two-port SRAM request arbiter
//
// Contents:
//   ADDR_W / DATA_W : controller address and data widths
//   state_e         : arbiter FSM states
//   grant_e         : which port owns the current transaction
//   other_port()    : the port that is not the given one (alternating priority)

package sram_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        GAP
    } state_e;

    typedef enum logic {
        CPU,
        VID
    } grant_e;

    function automatic grant_e other_port(input grant_e g);
        return (g == CPU) ? VID : CPU;
    endfunction

endpackage

// File: rtl/sram_arb_sync.sv
// rtl/sram_arb_sync.sv - 2-flop synchronizer with rising-edge detect
//
// Ports:
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   d_i     : asynchronous level input
//   rise_o  : one-cycle pulse when the synchronized level goes 0 -> 1

module sram_arb_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    // [0],[1] are the synchronizer stages, [2] holds the previous
    // synchronized level for the edge compare.
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - merges a wait-stated CPU port and a req/ack video read port onto one SRAM controller
//
// Ports:
//   clk_sdram, init_n            : controller clock, asynchronous active-low reset
//   cpu_addr/din/rd/we           : CPU request (levels, asynchronous to clk_sdram)
//   cpu_dout, cpu_wait           : CPU read data and wait, data valid when cpu_wait falls
//   vid_addr, vid_req            : video/DMA read request (synchronous), held until vid_ack
//   vid_dout, vid_ack            : video read data with a one-cycle completion pulse
//   mem_addr/din/rd/we           : to controller, strobes held REQ_HOLD cycles per issue
//   mem_dout, mem_wait           : from controller

module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int REQ_HOLD   = 4,
    parameter int MIN_SETTLE = 14,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 5
) (
    input  logic              clk_sdram,
    input  logic              init_n,

    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_rd,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_wait,

    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_req,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_ack,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_wait
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(REQ_HOLD - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(MIN_SETTLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e              state_q;
    grant_e              grant_q;
    grant_e              last_grant_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                cpu_pend_q;
    logic                cpu_wait_q;
    logic [ADDR_W-1:0]   cpu_addr_q;
    logic [DATA_W-1:0]   cpu_din_q;
    logic                cpu_we_q;
    logic [DATA_W-1:0]   cpu_dout_q;

    logic                vid_done_q;
    logic [DATA_W-1:0]   vid_dout_q;
    logic                vid_ack_q;

    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_din_q;
    logic                mem_rd_q;
    logic                mem_we_q;

    logic                cpu_rise;
    logic                vid_pend;
    logic                gnt_valid_d;
    grant_e              gnt_port_d;
    logic                settle_done;

    sram_arb_sync u_cpu_sync (
        .clk_i  (clk_sdram),
        .rst_ni (init_n),
        .d_i    (cpu_rd | cpu_we),
        .rise_o (cpu_rise)
    );

    // A held vid_req stays masked once acked until the requester drops it,
    // so one request is never serviced twice.
    assign vid_pend = vid_req & ~vid_done_q;

    // Completion needs both the minimum controller latency and mem_wait low;
    // mem_wait may never rise at all (e.g. repeated same-address reads).
    assign settle_done = (cnt_q >= SETTLE_LAST) && !mem_wait;

    always_comb begin
        gnt_valid_d = 1'b0;
        gnt_port_d  = last_grant_q;
        if (cpu_pend_q && vid_pend) begin
            gnt_valid_d = 1'b1;
            gnt_port_d  = other_port(last_grant_q);
        end else if (cpu_pend_q) begin
            gnt_valid_d = 1'b1;
            gnt_port_d  = CPU;
        end else if (vid_pend) begin
            gnt_valid_d = 1'b1;
            gnt_port_d  = VID;
        end
    end

    always_ff @(posedge clk_sdram or negedge init_n) begin
        if (!init_n) begin
            state_q      <= IDLE;
            grant_q      <= VID;
            last_grant_q <= VID;
            cnt_q        <= '0;
            cpu_pend_q   <= 1'b0;
            cpu_wait_q   <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_din_q    <= '0;
            cpu_we_q     <= 1'b0;
            cpu_dout_q   <= '0;
            vid_done_q   <= 1'b0;
            vid_dout_q   <= '0;
            vid_ack_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            vid_ack_q <= 1'b0;

            if (!vid_req) begin
                vid_done_q <= 1'b0;
            end

            // New CPU request; edges arriving while one is pending are dropped.
            if (cpu_rise && !cpu_pend_q) begin
                cpu_pend_q <= 1'b1;
                cpu_wait_q <= 1'b1;
                cpu_addr_q <= cpu_addr;
                cpu_din_q  <= cpu_din;
                cpu_we_q   <= cpu_we;
            end

            case (state_q)
                IDLE: begin
                    if (gnt_valid_d) begin
                        grant_q      <= gnt_port_d;
                        last_grant_q <= gnt_port_d;
                        cnt_q        <= '0;
                        state_q      <= ISSUE;
                        if (gnt_port_d == CPU) begin
                            mem_addr_q <= cpu_addr_q;
                            mem_din_q  <= cpu_din_q;
                            mem_we_q   <= cpu_we_q;
                            mem_rd_q   <= ~cpu_we_q;
                        end else begin
                            mem_addr_q <= vid_addr;
                            mem_din_q  <= '0;
                            mem_we_q   <= 1'b0;
                            mem_rd_q   <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == HOLD_LAST) begin
                        mem_rd_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                    if (settle_done) begin
                        // Writes also land here: the controller echoes write data.
                        if (grant_q == CPU) begin
                            cpu_dout_q <= mem_dout;
                            cpu_pend_q <= 1'b0;
                            cpu_wait_q <= 1'b0;
                        end else begin
                            vid_dout_q <= mem_dout;
                            vid_ack_q  <= 1'b1;
                            vid_done_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end
                end

                GAP: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_dout = cpu_dout_q;
    assign cpu_wait = cpu_wait_q;
    assign vid_dout = vid_dout_q;
    assign vid_ack  = vid_ack_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_rd   = mem_rd_q;
    assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter

module tb_sram_arbiter;

    localparam int REQ_HOLD   = 4;
    localparam int GAP_CYCLES = 2;

    logic        clk_sdram = 1'b0;
    logic        init_n    = 1'b0;
    logic [24:0] cpu_addr  = '0;
    logic [7:0]  cpu_din   = '0;
    logic        cpu_rd    = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [24:0] vid_addr  = '0;
    logic        vid_req   = 1'b0;
    logic [7:0]  vid_dout;
    logic        vid_ack;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic        mem_we;
    logic [7:0]  mem_dout  = '0;
    logic        mem_wait  = 1'b0;

    always #5 clk_sdram = ~clk_sdram;

    sram_arbiter dut (
        .clk_sdram (clk_sdram),
        .init_n    (init_n),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_rd    (cpu_rd),
        .cpu_we    (cpu_we),
        .cpu_dout  (cpu_dout),
        .cpu_wait  (cpu_wait),
        .vid_addr  (vid_addr),
        .vid_req   (vid_req),
        .vid_dout  (vid_dout),
        .vid_ack   (vid_ack),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_rd    (mem_rd),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .mem_wait  (mem_wait)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_vid;
        logic        is_wr;
        logic [24:0] addr;
        logic [7:0]  din;
        logic [7:0]  data;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input logic v, input logic w, input logic [24:0] a,
                            input logic [7:0] d, input logic [7:0] data, input int lat);
        exp_t e;
        e.is_vid = v; e.is_wr = w; e.addr = a; e.din = d; e.data = data; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // ---------------- controller model ----------------
    logic [7:0] ram [logic [24:0]];
    logic       model_wait_en  = 1'b0;
    int         model_wait_end = 13;

    initial begin
        int   mk;
        logic strobe_prev;
        mk = 1000;
        strobe_prev = 1'b0;
        forever begin
            @(negedge clk_sdram);
            if ((mem_rd || mem_we) && !strobe_prev) begin
                mk = 0;
                if (mem_we) begin
                    ram[mem_addr] = mem_din;
                    mem_dout = mem_din;
                end else begin
                    mem_dout = ram.exists(mem_addr) ? ram[mem_addr] : 8'h00;
                end
            end else if (mk < 1000) begin
                mk++;
            end
            strobe_prev = mem_rd || mem_we;
            mem_wait = model_wait_en && (mk >= 2) && (mk < model_wait_end);
        end
    end

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   n_rise = 0;
    int   n_ack = 0;

    initial begin
        int   rise_cyc, hi_cnt, lo_cnt;
        logic seen_fall, prev_strobe, prev_wait, prev_ack, strobe;
        exp_t e;
        rise_cyc = 0; hi_cnt = 0; lo_cnt = 0;
        seen_fall = 0; prev_strobe = 0; prev_wait = 0; prev_ack = 0;
        forever begin
            @(negedge clk_sdram);
            cyc++;
            if (!init_n) begin
                seen_fall = 0; prev_strobe = 0; prev_wait = 0; prev_ack = 0; hi_cnt = 0;
            end else begin
                strobe = mem_rd | mem_we;
                if (strobe && !prev_strobe) begin
                    n_rise++;
                    rise_cyc = cyc;
                    hi_cnt = 0;
                    if (seen_fall) check("gap_low_cycles", 32'(lo_cnt >= GAP_CYCLES), 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", 1, 0);
                    end else begin
                        e = exp_q[0];
                        check("issue_addr", mem_addr, e.addr);
                        check("issue_we", mem_we, e.is_wr);
                        check("issue_rd", mem_rd, !e.is_wr);
                        if (e.is_wr) check("issue_din", mem_din, e.din);
                    end
                end
                if (strobe) hi_cnt++;
                if (!strobe && prev_strobe) begin
                    check("strobe_width", hi_cnt, REQ_HOLD);
                    seen_fall = 1;
                    lo_cnt = 0;
                end
                if (!strobe) lo_cnt++;

                if ((prev_wait && !cpu_wait) || vid_ack) begin
                    if (vid_ack) begin
                        n_ack++;
                        if (prev_ack) check("vid_ack_width", 2, 1);
                    end
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_port", vid_ack, e.is_vid);
                        check("done_data", vid_ack ? vid_dout : cpu_dout, e.data);
                        check("done_latency", cyc - rise_cyc, e.lat);
                    end
                end
                prev_strobe = strobe;
                prev_wait   = cpu_wait;
                prev_ack    = vid_ack;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge clk_sdram);
        #1;
    endtask

    task automatic cpu_tx(input logic wr, input logic [24:0] a, input logic [7:0] d,
                          input logic [7:0] data, input int lat);
        logic ok;
        push_exp(1'b0, wr, a, d, data, lat);
        cpu_addr = a;
        cpu_din  = d;
        if (wr) cpu_we = 1'b1; else cpu_rd = 1'b1;
        ok = 0;
        for (int i = 0; i < 6 && !ok; i++) begin tick(); ok = cpu_wait; end
        check("cpu_wait_rise", ok, 1);
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin tick(); ok = !cpu_wait; end
        check("cpu_done_in_time", ok, 1);
        cpu_rd = 1'b0;
        cpu_we = 1'b0;
        repeat (4) tick();
    endtask

    task automatic vid_tx(input logic [24:0] a, input logic [7:0] data, input int lat,
                          output logic saw_wait);
        logic ok;
        push_exp(1'b1, 1'b0, a, 8'h00, data, lat);
        vid_addr = a;
        vid_req  = 1'b1;
        saw_wait = 0;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            tick();
            if (cpu_wait) saw_wait = 1;
            ok = vid_ack;
        end
        check("vid_ack_in_time", ok, 1);
        vid_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic contention(input logic vid_first, input logic [7:0] wdat, input logic [7:0] rdat);
        logic ok, cdone, vdone;
        ram[25'h0000300] = rdat;
        model_wait_en  = 1'b1;
        model_wait_end = 13;
        if (vid_first) begin
            push_exp(1'b1, 1'b0, 25'h0000300, 8'h00, rdat, 14);
            push_exp(1'b0, 1'b1, 25'h0000200, wdat, wdat, 14);
        end else begin
            push_exp(1'b0, 1'b1, 25'h0000200, wdat, wdat, 14);
            push_exp(1'b1, 1'b0, 25'h0000300, 8'h00, rdat, 14);
        end
        cpu_addr = 25'h0000200;
        cpu_din  = wdat;
        cpu_we   = 1'b1;
        ok = 0;
        for (int i = 0; i < 6 && !ok; i++) begin tick(); ok = cpu_wait; end
        check("cont_cpu_wait_rise", ok, 1);
        // CPU pending is now registered; raising vid_req here makes both
        // requests visible to the arbiter on the same IDLE cycle.
        vid_addr = 25'h0000300;
        vid_req  = 1'b1;
        cdone = 0;
        vdone = 0;
        for (int i = 0; i < 120 && !(cdone && vdone); i++) begin
            tick();
            if (vid_ack) begin vdone = 1; vid_req = 1'b0; end
            if (!cdone && !cpu_wait) begin cdone = 1; cpu_we = 1'b0; end
        end
        check("cont_both_done", cdone & vdone, 1);
        repeat (4) tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_vid;
        logic        is_wr;
        logic [24:0] addr;
        logic [7:0]  din;
        logic        preload;
        logic [7:0]  pre;
        logic        wait_en;
        int          wait_end;
        logic [7:0]  exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_wait;
        logic ok;
        int   r0, a0;

        vecs[0] = '{1'b0, 1'b0, 25'h0001234, 8'h00, 1'b1, 8'hA5, 1'b1, 13, 8'hA5, 14};
        vecs[1] = '{1'b1, 1'b0, 25'h1000000, 8'h00, 1'b1, 8'h3C, 1'b1, 13, 8'h3C, 14};
        vecs[2] = '{1'b0, 1'b1, 25'h0000010, 8'h5E, 1'b0, 8'h00, 1'b1, 20, 8'h5E, 21};
        vecs[3] = '{1'b1, 1'b0, 25'h1FFFFFF, 8'h00, 1'b1, 8'hC3, 1'b0, 0,  8'hC3, 14};
        vecs[4] = '{1'b0, 1'b0, 25'h0000010, 8'h00, 1'b0, 8'h00, 1'b0, 0,  8'h5E, 14};
        vecs[5] = '{1'b0, 1'b0, 25'h0000010, 8'h00, 1'b0, 8'h00, 1'b0, 0,  8'h5E, 14};
        vecs[6] = '{1'b0, 1'b0, 25'h0000000, 8'h00, 1'b1, 8'h81, 1'b1, 14, 8'h81, 15};

        repeat (3) tick();
        check("rst_mem_rd",   mem_rd,   0);
        check("rst_mem_we",   mem_we,   0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din",  mem_din,  0);
        check("rst_cpu_wait", cpu_wait, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_vid_dout", vid_dout, 0);
        check("rst_vid_ack",  vid_ack,  0);
        init_n = 1'b1;
        repeat (2) tick();

        foreach (vecs[k]) begin
            model_wait_en  = vecs[k].wait_en;
            model_wait_end = vecs[k].wait_end;
            if (vecs[k].preload) ram[vecs[k].addr] = vecs[k].pre;
            if (vecs[k].is_vid) begin
                vid_tx(vecs[k].addr, vecs[k].exp_data, vecs[k].exp_lat, saw_wait);
                check("cpu_wait_idle_during_vid", saw_wait, 0);
            end else begin
                cpu_tx(vecs[k].is_wr, vecs[k].addr, vecs[k].din, vecs[k].exp_data, vecs[k].exp_lat);
            end
        end

        // Contention with last grant = VID: CPU first. Then last grant = CPU: video first.
        model_wait_en = 1'b0;
        vid_tx(25'h1000000, 8'h3C, 14, saw_wait);
        contention(1'b0, 8'h77, 8'h99);
        model_wait_en = 1'b0;
        cpu_tx(1'b0, 25'h0001234, 8'h00, 8'hA5, 14);
        contention(1'b1, 8'h6B, 8'h42);

        // vid_req dropped during ISSUE: one ack, no re-issue.
        model_wait_en = 1'b0;
        ram[25'h0ABCDEF] = 8'hE7;
        r0 = n_rise;
        a0 = n_ack;
        push_exp(1'b1, 1'b0, 25'h0ABCDEF, 8'h00, 8'hE7, 14);
        vid_addr = 25'h0ABCDEF;
        vid_req  = 1'b1;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = mem_rd; end
        check("drop_issue_seen", ok, 1);
        tick();
        vid_req = 1'b0;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin tick(); ok = vid_ack; end
        check("drop_ack_seen", ok, 1);
        repeat (40) tick();
        check("drop_single_issue", n_rise - r0, 1);
        check("drop_single_ack", n_ack - a0, 1);

        // Reset during SETTLE aborts silently.
        model_wait_en  = 1'b1;
        model_wait_end = 13;
        ram[25'h0000444] = 8'h1D;
        push_exp(1'b1, 1'b0, 25'h0000444, 8'h00, 8'h1D, 14);
        vid_addr = 25'h0000444;
        vid_req  = 1'b1;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = mem_rd; end
        check("rst_seq_issue_seen", ok, 1);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = !mem_rd; end
        check("rst_seq_strobe_fell", ok, 1);
        repeat (3) tick();
        init_n  = 1'b0;
        vid_req = 1'b0;
        #1;
        check("midrst_mem_rd",   mem_rd,   0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_cpu_dout", cpu_dout, 0);
        check("midrst_vid_dout", vid_dout, 0);
        check("midrst_vid_ack",  vid_ack,  0);
        check("midrst_cpu_wait", cpu_wait, 0);
        exp_q.delete();
        r0 = n_rise;
        a0 = n_ack;
        repeat (2) tick();
        init_n = 1'b1;
        repeat (30) tick();
        check("midrst_no_ack", n_ack - a0, 0);
        check("midrst_no_issue", n_rise - r0, 0);
        cpu_tx(1'b0, 25'h0001234, 8'h00, 8'hA5, 14);

        repeat (5) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port request arbiter directly upstream of the SDRAM-backed static RAM controller.
- Merges the CPU port (level rd/we, wait-stated) and the video/DMA read port (req/ack) into the controller's single addr/din/rd/we/dout/wait interface.
- Generates edge-clean strobes the controller's 2-flop edge detector can see, and returns read data plus wait/ack to the winning port.

Parameters:
- REQ_HOLD, 4, cycles mem_rd/mem_we is held high per issue (covers controller 2-flop sync + edge detect)
- MIN_SETTLE, 14, minimum cycles from issue start before mem_wait low counts as completion (covers controller ACTIVE..READ+CL latency)
- GAP_CYCLES, 2, cycles mem_rd/mem_we held low between consecutive issues
- CNT_W, 5, width of internal cycle counter; must hold max(REQ_HOLD, MIN_SETTLE, GAP_CYCLES)

Ports:
- clk_sdram  in  1  controller clock (112 MHz)
- init_n  in  1  asynchronous active-low reset
- cpu_addr  in  25  CPU byte address
- cpu_din  in  8  CPU write data
- cpu_rd  in  1  CPU read request, level, held until cpu_wait low
- cpu_we  in  1  CPU write request, level
- cpu_dout  out  8  CPU read data, valid when cpu_wait falls
- cpu_wait  out  1  CPU wait
- vid_addr  in  25  video/DMA read address
- vid_req  in  1  video read request, held until vid_ack
- vid_dout  out  8  video read data, valid with vid_ack
- vid_ack  out  1  one-cycle completion pulse
- mem_addr  out  25  to controller addr
- mem_din  out  8  to controller din
- mem_rd  out  1  to controller rd
- mem_we  out  1  to controller we
- mem_dout  in  8  from controller dout
- mem_wait  in  1  from controller cpu_wait

Behaviour:
- Reset (init_n low, async): state IDLE; mem_rd=mem_we=0; mem_addr=0; mem_din=0; cpu_wait=0; cpu_dout=0; vid_dout=0; vid_ack=0; last_grant=VID; counter=0; CPU sync flops=0.
  - Reset mid-transaction aborts silently; no ack/data returned.
- CPU input capture:
  - cpu_rd/cpu_we pass a 2-flop synchronizer.
  - Rising edge of (rd|we) sets cpu_pend and cpu_wait=1 the same registered cycle, and latches cpu_addr, cpu_din and the we bit.
  - we has precedence if both are high.
- Video: vid_req is synchronous; a request is pending while vid_req=1 and no ack has been issued for it.
- Arbitration (in IDLE only):
  - Both pending: grant the port not equal to last_grant (alternating).
  - Single pending: grant it.
  - last_grant updates on grant.
- FSM:
  - IDLE: on grant, drive mem_addr/mem_din, raise mem_rd or mem_we, clear counter, go to ISSUE.
  - ISSUE: counter++; at counter==REQ_HOLD-1, drop strobe, go to SETTLE.
  - SETTLE: counter++ saturating. When counter>=MIN_SETTLE-1 and mem_wait==0:
    - Capture mem_dout into cpu_dout (CPU grant) or vid_dout (video grant, read only).
    - Clear cpu_pend and cpu_wait, or pulse vid_ack for one cycle.
    - Clear counter, go to GAP.
  - GAP: strobes low; at counter==GAP_CYCLES-1, go to IDLE.
- Writes also update cpu_dout with mem_dout (controller echoes write data).
- mem_addr/mem_din are stable from the IDLE grant until leaving GAP.
- A new CPU edge while cpu_pend=1 is ignored. CPU dropping rd/we mid-transaction does not abort; completion still clears cpu_wait.
- vid_req dropped before ack: the transaction completes, vid_ack still pulses, and the request is not re-issued.
- Back-to-back same-address reads still complete: completion relies on MIN_SETTLE plus mem_wait low, not on a mem_wait rise.
- Minimum service time per request: REQ_HOLD + MIN_SETTLE-REQ_HOLD + GAP = 16 cycles at defaults.

Decomposition:
- Package sram_arb_pkg: FSM state enum {IDLE, ISSUE, SETTLE, GAP}, grant enum {CPU, VID}, address/data width constants (25, 8).
- One sub-module: sram_arb_sync (2-flop synchronizer + rising-edge detect, async active-low reset), used for cpu_rd|cpu_we.

Test Plan:
- CPU read 0x0001234: controller model returns 0xA5 after mem_wait low at cycle 14 → mem_rd high exactly 4 cycles; cpu_wait low and cpu_dout=0xA5 on completion.
- Video read 0x1000000, model data 0x3C → vid_ack one-cycle pulse with vid_dout=0x3C; cpu_wait stays 0.
- cpu_we and vid_req rise the same cycle, last_grant=VID → CPU served first, video second; 2 low cycles on mem_rd/mem_we between issues.
- Two consecutive CPU reads of the same address with mem_wait never rising → both complete at MIN_SETTLE; no hang.
- init_n pulsed low during SETTLE → all outputs at reset values immediately; no vid_ack; next request served normally.
- vid_req dropped during ISSUE → single vid_ack still emitted; no second mem_rd issued.
